// File: rtl/fb_write_ctrl_pkg.sv
// Shared constants, fill FSM encoding and the RGB565 -> framebuffer pixel
// conversion used by the framebuffer write controller.
package fb_write_ctrl_pkg;

  localparam int FRAME_WIDTH   = 320;
  localparam int FRAME_HEIGHT  = 240;
  localparam int RESIZE_RATE   = 2;
  localparam int FB_ADDR_WIDTH = 16;
  localparam int FB_PIX_WIDTH  = 9;
  localparam int FB_WORDS_DEF  = FRAME_WIDTH * FRAME_HEIGHT / (RESIZE_RATE * RESIZE_RATE * 2);

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  // Keep the top three bits of each colour channel: {R[4:2], G[5:3], B[4:2]}.
  function automatic logic [FB_PIX_WIDTH-1:0] rgb565_to_pix(input logic [15:0] p);
    return {p[15:13], p[10:8], p[4:2]};
  endfunction

endpackage

// File: rtl/fb_fill_engine.sv
// Rectangle/clear fill engine: latches base, word count and colour on start
// and walks the word address forward once per granted cycle.
module fb_fill_engine
  import fb_write_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [FB_ADDR_WIDTH-1:0] i_base,
  input  logic [CNT_WIDTH-1:0]     i_words,
  input  logic [15:0]              i_color,
  input  logic                     i_grant,
  output logic                     o_req,
  output logic [FB_ADDR_WIDTH-1:0] o_addr,
  output logic [15:0]              o_color,
  output logic                     o_busy,
  output logic                     o_done,
  output fill_state_e              o_state
);

  localparam logic [FB_ADDR_WIDTH-1:0] WORD_MASK = {{(FB_ADDR_WIDTH-2){1'b1}}, 2'b00};

  fill_state_e              state_q, state_d;
  logic [FB_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [15:0]              color_q, color_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FILL_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  // Abort has priority over both start (in IDLE) and completion (in RUN).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      FILL_IDLE: begin
        if (i_start && !i_abort) begin
          if (i_words == '0) begin
            state_d = FILL_DONE;
          end else begin
            state_d = FILL_RUN;
            ptr_d   = i_base & WORD_MASK;
            cnt_d   = i_words;
            color_d = i_color;
          end
        end
      end
      FILL_RUN: begin
        if (i_abort) begin
          state_d = FILL_IDLE;
        end else if (i_grant) begin
          ptr_d = ptr_q + FB_ADDR_WIDTH'(4);
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) state_d = FILL_DONE;
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  assign o_req   = (state_q == FILL_RUN);
  assign o_busy  = (state_q == FILL_RUN);
  assign o_done  = (state_q == FILL_DONE);
  assign o_addr  = ptr_q;
  assign o_color = color_q;
  assign o_state = state_q;

endmodule

// File: rtl/fb_write_ctrl.sv
// Framebuffer write master: round-robin arbitration between CPU stores and the
// fill engine, RGB565 conversion, range checking and a registered write port.
module fb_write_ctrl
  import fb_write_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int FB_WORDS  = FB_WORDS_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cpu_valid,
  output logic                      o_cpu_ready,
  input  logic [FB_ADDR_WIDTH-1:0]  i_cpu_addr,
  input  logic [31:0]               i_cpu_data,
  input  logic                      i_fill_start,
  input  logic                      i_fill_abort,
  input  logic [FB_ADDR_WIDTH-1:0]  i_fill_base,
  input  logic [CNT_WIDTH-1:0]      i_fill_words,
  input  logic [15:0]               i_fill_color,
  output logic                      o_fill_busy,
  output logic                      o_fill_done,
  output logic                      o_err,
  input  logic                      i_err_clr,
  output logic                      o_fb_we,
  output logic [FB_ADDR_WIDTH-1:0]  o_fb_waddr,
  output logic [2*FB_PIX_WIDTH-1:0] o_fb_wdata,
  output logic [1:0]                o_dbg_fill_state
);

  localparam logic [FB_ADDR_WIDTH-1:0] WORD_MASK = {{(FB_ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [FB_ADDR_WIDTH-1:0] WORDS_LIM = FB_WORDS[FB_ADDR_WIDTH-1:0];

  logic                      we_q, we_d;
  logic [FB_ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [2*FB_PIX_WIDTH-1:0] wdata_q, wdata_d;
  logic                      err_q, err_d;
  logic                      cpu_turn_q, cpu_turn_d;
  logic                      live_q;

  logic                      fill_req, fill_busy, fill_done;
  logic [FB_ADDR_WIDTH-1:0]  fill_addr;
  logic [15:0]               fill_color;
  fill_state_e               fill_state;

  logic                      cpu_grant, fill_grant, any_grant, in_range;
  logic [FB_ADDR_WIDTH-1:0]  wr_addr;
  logic [31:0]               wr_data;

  fb_fill_engine #(.CNT_WIDTH(CNT_WIDTH)) u_fill (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_fill_start),
    .i_abort (i_fill_abort),
    .i_base  (i_fill_base),
    .i_words (i_fill_words),
    .i_color (i_fill_color),
    .i_grant (fill_grant),
    .o_req   (fill_req),
    .o_addr  (fill_addr),
    .o_color (fill_color),
    .o_busy  (fill_busy),
    .o_done  (fill_done),
    .o_state (fill_state)
  );

  // CPU handshake: a word is transferred in any cycle where i_cpu_valid and
  // o_cpu_ready are both high. Ready depends on registered state only, so the
  // CPU may hold or drop valid freely; live_q keeps ready low while in reset.
  assign o_cpu_ready = live_q && (!fill_busy || cpu_turn_q);
  assign cpu_grant   = i_cpu_valid && o_cpu_ready;
  assign fill_grant  = fill_req && !cpu_grant;
  assign any_grant   = cpu_grant || fill_grant;

  assign wr_addr  = cpu_grant ? i_cpu_addr : fill_addr;
  assign wr_data  = cpu_grant ? i_cpu_data : {fill_color, fill_color};
  assign in_range = {2'b00, wr_addr[FB_ADDR_WIDTH-1:2]} < WORDS_LIM;

  always_comb begin
    we_d       = any_grant && in_range;
    waddr_d    = wr_addr & WORD_MASK;
    wdata_d    = {rgb565_to_pix(wr_data[31:16]), rgb565_to_pix(wr_data[15:0])};
    cpu_turn_d = cpu_turn_q;
    if (cpu_grant)       cpu_turn_d = 1'b0;
    else if (fill_grant) cpu_turn_d = 1'b1;
    // A new out-of-range write beats a simultaneous clear.
    err_d = err_q;
    if (any_grant && !in_range) err_d = 1'b1;
    else if (i_err_clr)         err_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cpu_turn_q <= 1'b1;
      live_q     <= 1'b0;
    end else begin
      we_q       <= we_d;
      if (we_d) begin
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
      end
      err_q      <= err_d;
      cpu_turn_q <= cpu_turn_d;
      live_q     <= 1'b1;
    end
  end

  assign o_fb_we          = we_q;
  assign o_fb_waddr       = waddr_q;
  assign o_fb_wdata       = wdata_q;
  assign o_err            = err_q;
  assign o_fill_busy      = fill_busy;
  assign o_fill_done      = fill_done;
  assign o_dbg_fill_state = fill_state;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Scoreboard bench for fb_write_ctrl: a cycle-level reference model predicts
// every framebuffer write and the status outputs.
module tb_fb_write_ctrl;

  localparam int FB_WORDS = 320 * 240 / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic        fill_start = 1'b0;
  logic        fill_abort = 1'b0;
  logic [15:0] fill_base = '0;
  logic [15:0] fill_words = '0;
  logic [15:0] fill_color = '0;
  logic        fill_busy, fill_done, err;
  logic        err_clr = 1'b0;
  logic        fb_we;
  logic [15:0] fb_waddr;
  logic [17:0] fb_wdata;
  logic [1:0]  dbg_state;

  fb_write_ctrl dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cpu_valid      (cpu_valid),
    .o_cpu_ready      (cpu_ready),
    .i_cpu_addr       (cpu_addr),
    .i_cpu_data       (cpu_data),
    .i_fill_start     (fill_start),
    .i_fill_abort     (fill_abort),
    .i_fill_base      (fill_base),
    .i_fill_words     (fill_words),
    .i_fill_color     (fill_color),
    .o_fill_busy      (fill_busy),
    .o_fill_done      (fill_done),
    .o_err            (err),
    .i_err_clr        (err_clr),
    .o_fb_we          (fb_we),
    .o_fb_waddr       (fb_waddr),
    .o_fb_wdata       (fb_wdata),
    .o_dbg_fill_state (dbg_state)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [33:0] exp_q[$];

  // Reference model: fill activity (0 idle, 1 running, 2 finishing), who has
  // priority next, the remaining fill job and the sticky error.
  int          m_phase;
  bit          m_cpu_turn;
  int          m_left;
  int          m_ptr;
  logic [15:0] m_color;
  bit          m_err;
  bit          m_bad;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_conv(input logic [15:0] p);
    int v, r, g, b;
    v = int'(p);
    r = v / 2048;
    g = (v / 32) % 64;
    b = v % 32;
    return 9'((r / 4) * 64 + (g / 8) * 8 + (b / 4));
  endfunction

  task automatic model_write(input int addr, input logic [31:0] data);
    if ((addr / 4) < FB_WORDS)
      exp_q.push_back({16'(addr - (addr % 4)), ref_conv(data[31:16]), ref_conv(data[15:0])});
    else
      m_bad = 1'b1;
  endtask

  // Monitor: every write the DUT presents must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst && fb_we) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got %h/%h expected none", fb_waddr, fb_wdata);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({fb_waddr, fb_wdata} !== e) begin
          mismatched++;
          $display("FAIL fb_write: got %h expected %h at %0t", {fb_waddr, fb_wdata}, e, $time);
        end
      end
    end
  end

  task automatic step(input logic cv, input int ca, input logic [31:0] cd,
                      input logic fs, input logic fa, input int fb, input int fw,
                      input logic [15:0] fc, input logic ec);
    bit ready, cpu_go, fill_go;
    @(negedge clk);
    ready = (m_phase != 1) || m_cpu_turn;
    check("cpu_ready", 34'(cpu_ready), 34'(ready));
    check("fill_busy", 34'(fill_busy), 34'(m_phase == 1));
    check("fill_done", 34'(fill_done), 34'(m_phase == 2));
    check("err",       34'(err),       34'(m_err));
    cpu_valid  = cv;
    cpu_addr   = 16'(ca);
    cpu_data   = cd;
    fill_start = fs;
    fill_abort = fa;
    fill_base  = 16'(fb);
    fill_words = 16'(fw);
    fill_color = fc;
    err_clr    = ec;
    cpu_go  = cv && ready;
    fill_go = (m_phase == 1) && !cpu_go;
    m_bad   = 1'b0;
    if (cpu_go) begin
      model_write(ca % 65536, cd);
      m_cpu_turn = 1'b0;
    end else if (fill_go) begin
      model_write(m_ptr, {m_color, m_color});
      m_cpu_turn = 1'b1;
    end
    if (m_bad)   m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    case (m_phase)
      0: if (fs && !fa) begin
        if (fw == 0) m_phase = 2;
        else begin
          m_phase = 1;
          m_ptr   = (fb % 65536) - (fb % 4);
          m_left  = fw;
          m_color = fc;
        end
      end
      1: if (fa) m_phase = 0;
         else if (fill_go) begin
           m_ptr  = (m_ptr + 4) % 65536;
           m_left = m_left - 1;
           if (m_left == 0) m_phase = 2;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cpu_valid = 0; fill_start = 0; fill_abort = 0; err_clr = 0;
    rst = 1'b1;
    #1;
    check("rst_we",    34'(fb_we),     34'(0));
    check("rst_waddr", 34'(fb_waddr),  34'(0));
    check("rst_wdata", 34'(fb_wdata),  34'(0));
    check("rst_ready", 34'(cpu_ready), 34'(0));
    check("rst_busy",  34'(fill_busy), 34'(0));
    check("rst_done",  34'(fill_done), 34'(0));
    check("rst_err",   34'(err),       34'(0));
    exp_q.delete();
    m_phase = 0; m_cpu_turn = 1'b1; m_err = 1'b0; m_left = 0; m_ptr = 0; m_color = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // CPU-only store, with a literal check of the converted word.
    step(1, 'h10, 32'hF800_07E0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("t1_we",    34'(fb_we),    34'(1));
    check("t1_waddr", 34'(fb_waddr), 34'(16'h0010));
    check("t1_wdata", 34'(fb_wdata), 34'({9'h1C0, 9'h038}));
    idle(2);

    // Plain fill of four words in blue.
    step(0, 0, 0, 1, 0, 'h0, 4, 16'h001F, 0);
    idle(7);

    // Contention: CPU valid every cycle against a 6-word fill.
    step(0, 0, 0, 1, 0, 'h400, 6, 16'hFFFF, 0);
    for (int i = 0; i < 14; i++) step(1, 'h2000 + 4 * i, $urandom, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Abort after two fill writes, then a zero-length fill.
    step(0, 0, 0, 1, 0, 'h100, 10, 16'h07E0, 0);
    idle(2);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 0, 'h300, 0, 16'h1234, 0);
    idle(3);

    // Out-of-range store, sticky error, clear, then set-beats-clear.
    step(1, FB_WORDS * 4, $urandom, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, FB_WORDS * 4 + 8, $urandom, 0, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, FB_WORDS * 4 - 4, $urandom, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Reset in the middle of a long fill, then a fresh fill elsewhere.
    step(0, 0, 0, 1, 0, 'h800, 100, 16'hF81F, 0);
    idle(5);
    @(posedge clk); #2;
    do_reset();
    step(0, 0, 0, 1, 0, 'h203, 3, 16'h8410, 0);
    idle(5);

    // Randomised traffic, including fills that run off the end of the buffer.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1,
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, FB_WORDS * 4 + 64)),
           $urandom,
           $urandom_range(0, 12) == 0,
           $urandom_range(0, 30) == 0,
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(FB_WORDS * 4 - 32, 65535)) : int'($urandom_range(0, 4096)),
           ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 12)),
           16'($urandom),
           $urandom_range(0, 20) == 0);
    end
    idle(20);
    @(negedge clk);
    check("exp_q_drained", 34'(exp_q.size()), 34'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
